// File: rtl/axi_id_remap_table.sv
// Remaps slave-port AXI IDs onto table indices (ID in channel MSBs, R.last in bit 0); zero latency.
// Requests stall (ready=0, valid=0) on a saturated matching entry or a full table; responses pass through.

module axi_id_remap_side #(
  parameter int unsigned IdWidth    = 6,
  parameter int unsigned NumEntries = 4,
  parameter int unsigned MaxTxns    = 4,
  parameter int unsigned IdxWidth   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic [IdWidth-1:0]  req_id,
  input  logic                down_ready,
  output logic                up_ready,
  output logic                down_valid,
  output logic [IdxWidth-1:0] req_idx,
  input  logic                resp_valid,
  input  logic                resp_ready,
  input  logic                resp_last,
  input  logic [IdxWidth-1:0] resp_idx,
  output logic [IdWidth-1:0]  resp_id,
  output logic                full
);
  localparam int unsigned CntWidth = $clog2(MaxTxns + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTxns);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic                ent_vld [NumEntries];
  logic [IdWidth-1:0]  ent_sid [NumEntries];
  logic [CntWidth-1:0] ent_cnt [NumEntries];

  logic                lat_vld;
  logic [IdxWidth-1:0] lat_idx;

  logic                hit, hit_room, has_free, sel_ok, push, pop, resp_known;
  logic [IdxWidth-1:0] hit_idx, free_idx;

  // Descending scan so the lowest-index free entry wins.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    hit_room   = 1'b0;
    has_free   = 1'b0;
    free_idx   = '0;
    resp_id    = '0;
    resp_known = 1'b0;
    full       = 1'b1;
    for (int i = NumEntries - 1; i >= 0; i--) begin
      if (ent_vld[i] && (ent_sid[i] == req_id)) begin
        hit      = 1'b1;
        hit_idx  = IdxWidth'(i);
        hit_room = (ent_cnt[i] < CntMax);
      end
      if (!ent_vld[i]) begin
        has_free = 1'b1;
        free_idx = IdxWidth'(i);
      end
      if (resp_idx == IdxWidth'(i)) begin
        resp_id    = ent_sid[i];
        resp_known = ent_vld[i];
      end
      full = full & ent_vld[i];
    end
  end

  // Once offered downstream, the index is frozen until the handshake, even if the table changes.
  always_comb begin
    if (lat_vld) begin
      req_idx = lat_idx;
      sel_ok  = 1'b1;
    end else if (hit) begin
      req_idx = hit_idx;
      sel_ok  = hit_room;
    end else begin
      req_idx = free_idx;
      sel_ok  = has_free;
    end
  end

  assign down_valid = req_valid & sel_ok;
  assign up_ready   = down_ready & sel_ok;
  assign push       = down_valid & down_ready;
  assign pop        = resp_valid & resp_ready & resp_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_vld <= 1'b0;
      lat_idx <= '0;
    end else if (push) begin
      lat_vld <= 1'b0;
    end else if (down_valid) begin
      lat_vld <= 1'b1;
      lat_idx <= req_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumEntries; i++) begin
        ent_vld[i] <= 1'b0;
        ent_sid[i] <= '0;
        ent_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumEntries; i++) begin
        // A push and pop on the same entry cancel: count and valid are left alone.
        if (push && (req_idx == IdxWidth'(i)) && !(pop && (resp_idx == IdxWidth'(i)))) begin
          ent_vld[i] <= 1'b1;
          ent_sid[i] <= req_id;
          ent_cnt[i] <= ent_cnt[i] + CntOne;
        end else if (pop && (resp_idx == IdxWidth'(i)) && !(push && (req_idx == IdxWidth'(i)))) begin
          ent_cnt[i] <= ent_cnt[i] - CntOne;
          if (ent_cnt[i] == CntOne) ent_vld[i] <= 1'b0;
        end
      end
    end
  end

  resp_to_live_entry: assert property (@(posedge clk) disable iff (!rst_n)
    (resp_valid && resp_ready) |-> resp_known);

endmodule

module axi_id_remap_table #(
  parameter int unsigned AxiSlvPortIdWidth    = 6,
  parameter int unsigned AxiSlvPortMaxUniqIds = 4,
  parameter int unsigned AxiMaxTxnsPerId      = 4,
  parameter int unsigned AxiMstPortIdWidth    =
    ($clog2(AxiSlvPortMaxUniqIds) > 0) ? $clog2(AxiSlvPortMaxUniqIds) : 1,
  parameter type slv_aw_chan_t = logic,
  parameter type slv_b_chan_t  = logic,
  parameter type slv_ar_chan_t = logic,
  parameter type slv_r_chan_t  = logic,
  parameter type mst_aw_chan_t = logic,
  parameter type mst_b_chan_t  = logic,
  parameter type mst_ar_chan_t = logic,
  parameter type mst_r_chan_t  = logic,
  parameter type w_chan_t      = logic
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  slv_aw_chan_t slv_aw_chan_i,
  input  logic         slv_aw_valid_i,
  output logic         slv_aw_ready_o,
  input  w_chan_t      slv_w_chan_i,
  input  logic         slv_w_valid_i,
  output logic         slv_w_ready_o,
  output slv_b_chan_t  slv_b_chan_o,
  output logic         slv_b_valid_o,
  input  logic         slv_b_ready_i,
  input  slv_ar_chan_t slv_ar_chan_i,
  input  logic         slv_ar_valid_i,
  output logic         slv_ar_ready_o,
  output slv_r_chan_t  slv_r_chan_o,
  output logic         slv_r_valid_o,
  input  logic         slv_r_ready_i,
  output mst_aw_chan_t mst_aw_chan_o,
  output logic         mst_aw_valid_o,
  input  logic         mst_aw_ready_i,
  output w_chan_t      mst_w_chan_o,
  output logic         mst_w_valid_o,
  input  logic         mst_w_ready_i,
  input  mst_b_chan_t  mst_b_chan_i,
  input  logic         mst_b_valid_i,
  output logic         mst_b_ready_o,
  output mst_ar_chan_t mst_ar_chan_o,
  output logic         mst_ar_valid_o,
  input  logic         mst_ar_ready_i,
  input  mst_r_chan_t  mst_r_chan_i,
  input  logic         mst_r_valid_i,
  output logic         mst_r_ready_o,
  output logic         wr_full_o,
  output logic         rd_full_o
);
  localparam int unsigned SlvW = AxiSlvPortIdWidth;
  localparam int unsigned MstW = AxiMstPortIdWidth;
  localparam int unsigned AwSW = $bits(slv_aw_chan_t);
  localparam int unsigned AwMW = $bits(mst_aw_chan_t);
  localparam int unsigned ArSW = $bits(slv_ar_chan_t);
  localparam int unsigned ArMW = $bits(mst_ar_chan_t);
  localparam int unsigned BSW  = $bits(slv_b_chan_t);
  localparam int unsigned BMW  = $bits(mst_b_chan_t);
  localparam int unsigned RSW  = $bits(slv_r_chan_t);
  localparam int unsigned RMW  = $bits(mst_r_chan_t);
  localparam bit StructMode = (AwSW > SlvW) && (ArSW > SlvW) && (BSW > SlvW) && (RSW > SlvW) &&
                              (AwMW > MstW) && (ArMW > MstW) && (BMW > MstW) && (RMW > MstW);

  logic [AwSW-1:0] aw_s;
  logic [AwMW-1:0] aw_m;
  logic [ArSW-1:0] ar_s;
  logic [ArMW-1:0] ar_m;
  logic [BSW-1:0]  b_s;
  logic [BMW-1:0]  b_m;
  logic [RSW-1:0]  r_s;
  logic [RMW-1:0]  r_m;

  logic [SlvW-1:0] aw_id, ar_id, b_id, r_id;
  logic [MstW-1:0] aw_idx, ar_idx, b_idx, r_idx;

  assign aw_s          = slv_aw_chan_i;
  assign ar_s          = slv_ar_chan_i;
  assign b_m           = mst_b_chan_i;
  assign r_m           = mst_r_chan_i;
  assign mst_aw_chan_o = aw_m;
  assign mst_ar_chan_o = ar_m;
  assign slv_b_chan_o  = b_s;
  assign slv_r_chan_o  = r_s;

  if (StructMode) begin : g_struct
    assign aw_id = aw_s[AwSW-1 -: SlvW];
    assign aw_m  = {aw_idx, aw_s[AwSW-SlvW-1:0]};
    assign ar_id = ar_s[ArSW-1 -: SlvW];
    assign ar_m  = {ar_idx, ar_s[ArSW-SlvW-1:0]};
    assign b_idx = b_m[BMW-1 -: MstW];
    assign b_s   = {b_id, b_m[BMW-MstW-1:0]};
    assign r_idx = r_m[RMW-1 -: MstW];
    assign r_s   = {r_id, r_m[RMW-MstW-1:0]};
  end else begin : g_scalar
    // Scalar channel types carry nothing but the ID.
    assign aw_id = SlvW'(aw_s);
    assign aw_m  = AwMW'(aw_idx);
    assign ar_id = SlvW'(ar_s);
    assign ar_m  = ArMW'(ar_idx);
    assign b_idx = MstW'(b_m);
    assign b_s   = BSW'(b_id);
    assign r_idx = MstW'(r_m);
    assign r_s   = RSW'(r_id);
  end

  axi_id_remap_side #(
    .IdWidth(SlvW), .NumEntries(AxiSlvPortMaxUniqIds), .MaxTxns(AxiMaxTxnsPerId), .IdxWidth(MstW)
  ) u_wr (
    .clk(clk_i), .rst_n(rst_ni),
    .req_valid(slv_aw_valid_i), .req_id(aw_id), .down_ready(mst_aw_ready_i),
    .up_ready(slv_aw_ready_o), .down_valid(mst_aw_valid_o), .req_idx(aw_idx),
    .resp_valid(mst_b_valid_i), .resp_ready(slv_b_ready_i), .resp_last(1'b1),
    .resp_idx(b_idx), .resp_id(b_id), .full(wr_full_o)
  );

  axi_id_remap_side #(
    .IdWidth(SlvW), .NumEntries(AxiSlvPortMaxUniqIds), .MaxTxns(AxiMaxTxnsPerId), .IdxWidth(MstW)
  ) u_rd (
    .clk(clk_i), .rst_n(rst_ni),
    .req_valid(slv_ar_valid_i), .req_id(ar_id), .down_ready(mst_ar_ready_i),
    .up_ready(slv_ar_ready_o), .down_valid(mst_ar_valid_o), .req_idx(ar_idx),
    .resp_valid(mst_r_valid_i), .resp_ready(slv_r_ready_i), .resp_last(r_m[0]),
    .resp_idx(r_idx), .resp_id(r_id), .full(rd_full_o)
  );

  assign slv_b_valid_o = mst_b_valid_i;
  assign mst_b_ready_o = slv_b_ready_i;
  assign slv_r_valid_o = mst_r_valid_i;
  assign mst_r_ready_o = slv_r_ready_i;

  assign mst_w_chan_o  = slv_w_chan_i;
  assign mst_w_valid_o = slv_w_valid_i;
  assign slv_w_ready_o = mst_w_ready_i;

endmodule
